// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, exception codes and bus payload layouts for
// the write-back stage. Bus structs are declared MSB first so that a plain
// cast from the flat port vector lines the fields up.
package wb_stage_pkg;

  localparam int unsigned MS_WS_BUS_W  = 200;
  localparam int unsigned WB_CSR_BUS_W = 200;

  // Bits of ms_to_ws_bus actually carrying fields; the rest are reserved.
  localparam int unsigned MS_WS_USED_W = 199;
  localparam int unsigned MS_WS_RSVD_W = MS_WS_BUS_W - MS_WS_USED_W;

  localparam logic [5:0] ECODE_INT = 6'h00;

  // Memory stage -> write-back stage payload.
  typedef struct packed {
    logic [MS_WS_RSVD_W-1:0] rsvd;
    logic [31:0]             pc;
    logic                    gr_we;
    logic [4:0]              dest;
    logic [31:0]             result;
    logic                    csr_re;
    logic                    csr_we;
    logic [13:0]             csr_num;
    logic [31:0]             csr_wmask;
    logic [31:0]             csr_wvalue;
    logic                    ex;
    logic [5:0]              ecode;
    logic [8:0]              esubcode;
    logic                    ertn;
    logic [31:0]             vaddr;
  } ms_ws_bus_t;

  // Write-back stage -> CSR file payload.
  typedef struct packed {
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] pc;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        ipi_int_in;
    logic [31:0] coreid_in;
    logic [7:0]  hw_int_in;
    logic [31:0] vaddr;
  } wb_csr_bus_t;

endpackage

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the five-stage LoongArch pipeline.
// Holds one retiring instruction under a valid/allowin handshake, commits its
// GPR write, packs the CSR write-back bus and raises the pipeline flush for
// exceptions, pending interrupts and ertn.
// Ports:
//   clk, reset (sync, active-high)
//   ms_to_ws_valid/ms_to_ws_bus in, ws_allowin out   - upstream handshake
//   hw_int_in, ipi_int_in, coreid_in                 - forwarded to CSR bus
//   csr_rvalue, has_int, ex_entry, ertn_entry        - from CSR file
//   wb_csr_bus, wb_ex, ertn_flush                    - to CSR file
//   ws_flush, flush_target                           - pipeline redirect
//   rf_we, rf_waddr, rf_wdata, ws_fwd_valid          - GPR write / forwarding
//   inst_retired                                     - retired instruction count
// Optional: define WB_DEBUG_TRACE_EN to add the debug_wb_* trace ports.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ms_to_ws_valid,
  output logic                    ws_allowin,
  input  logic [MS_WS_BUS_W-1:0]  ms_to_ws_bus,
  input  logic [7:0]              hw_int_in,
  input  logic                    ipi_int_in,
  input  logic [31:0]             coreid_in,
  input  logic [31:0]             csr_rvalue,
  input  logic                    has_int,
  input  logic [31:0]             ex_entry,
  input  logic [31:0]             ertn_entry,
  output logic [WB_CSR_BUS_W-1:0] wb_csr_bus,
  output logic                    wb_ex,
  output logic                    ertn_flush,
  output logic                    ws_flush,
  output logic [31:0]             flush_target,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic                    ws_fwd_valid,
  output logic [31:0]             inst_retired
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_we,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
`endif
);

  ms_ws_bus_t  bus_q, bus_d;
  logic        ws_valid_q, ws_valid_d;
  logic [31:0] inst_retired_q, inst_retired_d;
  logic        ws_ready_go;
  logic        int_take;
  logic        commit_ok;
  wb_csr_bus_t csr_bus;

  // Reserved upper bits of the incoming bus carry nothing.
  logic unused_rsvd;
  assign unused_rsvd = ^bus_q.rsvd;

  // Commit decode: exceptions/interrupts beat ertn, and both suppress side effects.
  always_comb begin : commit_logic
    ws_ready_go  = 1'b1;
    ws_allowin   = !ws_valid_q || ws_ready_go;
    int_take     = ws_valid_q && has_int && !bus_q.ex;
    wb_ex        = ws_valid_q && (bus_q.ex || has_int);
    ertn_flush   = ws_valid_q && bus_q.ertn && !wb_ex;
    ws_flush     = wb_ex || ertn_flush;
    flush_target = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : 32'h0);
    commit_ok    = ws_valid_q && !wb_ex;
    rf_we        = commit_ok && bus_q.gr_we;
    rf_waddr     = bus_q.dest;
    rf_wdata     = bus_q.csr_re ? csr_rvalue : bus_q.result;
    ws_fwd_valid = rf_we && (rf_waddr != 5'd0);
    inst_retired = inst_retired_q;

    csr_bus.csr_re     = commit_ok && bus_q.csr_re;
    csr_bus.csr_we     = commit_ok && bus_q.csr_we;
    csr_bus.csr_num    = bus_q.csr_num;
    csr_bus.csr_wmask  = bus_q.csr_wmask;
    csr_bus.csr_wvalue = bus_q.csr_wvalue;
    csr_bus.pc         = bus_q.pc;
    // A taken interrupt is reported as INT regardless of the bus code.
    csr_bus.ecode      = int_take ? ECODE_INT : bus_q.ecode;
    csr_bus.esubcode   = int_take ? 9'h000 : bus_q.esubcode;
    csr_bus.ipi_int_in = ipi_int_in;
    csr_bus.coreid_in  = coreid_in;
    csr_bus.hw_int_in  = hw_int_in;
    csr_bus.vaddr      = bus_q.vaddr;
    wb_csr_bus         = WB_CSR_BUS_W'(csr_bus);
  end

`ifdef WB_DEBUG_TRACE_EN
  // Trace view of the committing instruction.
  always_comb begin : debug_trace
    debug_wb_pc       = bus_q.pc;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
`endif

  // Next-state: a flush drops the incoming instruction along with the held one.
  always_comb begin : next_state
    ws_valid_d     = ws_valid_q;
    bus_d          = bus_q;
    inst_retired_d = inst_retired_q;
    if (ws_flush) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
    end
    if (ms_to_ws_valid && ws_allowin && !ws_flush) begin
      bus_d = ms_ws_bus_t'(ms_to_ws_bus);
    end
    if (commit_ok) begin
      inst_retired_d = inst_retired_q + 32'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin : state_regs
    if (reset) begin
      ws_valid_q     <= 1'b0;
      bus_q          <= '0;
      inst_retired_q <= 32'd0;
    end else begin
      ws_valid_q     <= ws_valid_d;
      bus_q          <= bus_d;
      inst_retired_q <= inst_retired_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage. A per-cycle reference model
// holds the resident instruction as a record and derives every commit output
// from the stage's commit rules; directed cases are followed by random traffic.
module tb_wb_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        ertn;
    logic [31:0] vaddr;
  } rec_t;

  localparam logic [31:0] EX_ENTRY   = 32'h1c008000;
  localparam logic [31:0] ERTN_ENTRY = 32'h1c000100;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_to_ws_valid;
  logic         ws_allowin;
  logic [199:0] ms_to_ws_bus;
  logic [7:0]   hw_int_in;
  logic         ipi_int_in;
  logic [31:0]  coreid_in;
  logic [31:0]  csr_rvalue;
  logic         has_int;
  logic [31:0]  ex_entry;
  logic [31:0]  ertn_entry;
  logic [199:0] wb_csr_bus;
  logic         wb_ex;
  logic         ertn_flush;
  logic         ws_flush;
  logic [31:0]  flush_target;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         ws_fwd_valid;
  logic [31:0]  inst_retired;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_to_ws_bus(ms_to_ws_bus),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .coreid_in(coreid_in),
    .csr_rvalue(csr_rvalue), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry),
    .wb_csr_bus(wb_csr_bus), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .ws_flush(ws_flush), .flush_target(flush_target),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_valid(ws_fwd_valid), .inst_retired(inst_retired)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model: what is resident in the stage and how many have retired.
  logic        m_valid = 1'b0;
  rec_t        m_rec   = '0;
  logic [31:0] m_ret   = 32'd0;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, check outputs against the model,
  // then advance the model to what the next posedge must produce.
  task automatic step(input logic v, input rec_t r, input logic hi,
                      input logic [31:0] crv, input logic rst);
    logic         e_int, e_wbex, e_ertn, e_flush, gate, e_rfwe;
    logic [31:0]  e_tgt, e_wdata;
    logic [199:0] e_bus;
    @(negedge clk);
    reset          = rst;
    ms_to_ws_valid = v;
    ms_to_ws_bus   = {1'b0, r};
    has_int        = hi;
    csr_rvalue     = crv;
    hw_int_in      = 8'($urandom);
    ipi_int_in     = 1'($urandom);
    coreid_in      = $urandom;
    #1;
    e_int   = m_valid && hi && !m_rec.ex;
    e_wbex  = m_valid && (m_rec.ex || hi);
    e_ertn  = m_valid && m_rec.ertn && !e_wbex;
    e_flush = e_wbex || e_ertn;
    e_tgt   = e_wbex ? EX_ENTRY : (e_ertn ? ERTN_ENTRY : 32'h0);
    gate    = m_valid && !e_wbex;
    e_rfwe  = gate && m_rec.gr_we;
    e_wdata = m_rec.csr_re ? crv : m_rec.result;
    e_bus   = {gate && m_rec.csr_re, gate && m_rec.csr_we, m_rec.csr_num,
               m_rec.csr_wmask, m_rec.csr_wvalue, m_rec.pc,
               e_int ? 6'h00 : m_rec.ecode, e_int ? 9'h000 : m_rec.esubcode,
               ipi_int_in, coreid_in, hw_int_in, m_rec.vaddr};
    chk("allowin", 200'(ws_allowin), 200'(1'b1));
    chk("wb_ex", 200'(wb_ex), 200'(e_wbex));
    chk("ertn_flush", 200'(ertn_flush), 200'(e_ertn));
    chk("ws_flush", 200'(ws_flush), 200'(e_flush));
    chk("flush_target", 200'(flush_target), 200'(e_tgt));
    chk("rf_we", 200'(rf_we), 200'(e_rfwe));
    chk("fwd_valid", 200'(ws_fwd_valid), 200'(e_rfwe && m_rec.dest != 5'd0));
    chk("csr_bus", wb_csr_bus, e_bus);
    chk("inst_retired", 200'(inst_retired), 200'(m_ret));
    if (e_rfwe) begin
      chk("rf_waddr", 200'(rf_waddr), 200'(m_rec.dest));
      chk("rf_wdata", 200'(rf_wdata), 200'(e_wdata));
    end
    if (rst) begin
      m_valid = 1'b0;
      m_ret   = 32'd0;
      m_rec   = '0;
    end else begin
      if (gate) m_ret = m_ret + 32'd1;
      m_valid = e_flush ? 1'b0 : v;
      if (v && !e_flush) m_rec = r;
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.pc         = $urandom;
    r.gr_we      = 1'($urandom);
    r.dest       = 5'($urandom);
    r.result     = $urandom;
    r.csr_re     = 1'($urandom);
    r.csr_we     = 1'($urandom);
    r.csr_num    = 14'($urandom);
    r.csr_wmask  = $urandom;
    r.csr_wvalue = $urandom;
    r.ex         = ($urandom_range(0, 7) == 0);
    r.ecode      = 6'($urandom);
    r.esubcode   = 9'($urandom);
    r.ertn       = ($urandom_range(0, 7) == 0);
    r.vaddr      = $urandom;
    return r;
  endfunction

  initial begin
    rec_t        z, r;
    logic [31:0] ret_snap;
    z = '0;
    ex_entry       = EX_ENTRY;
    ertn_entry     = ERTN_ENTRY;
    reset          = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    has_int        = 1'b0;
    csr_rvalue     = '0;
    hw_int_in      = '0;
    ipi_int_in     = 1'b0;
    coreid_in      = '0;
    repeat (2) @(posedge clk);

    // Reset state, with a stray interrupt that must be ignored.
    step(1'b0, z, 1'b1, 32'h0, 1'b0);
    chk("rst_wb_ex", 200'(wb_ex), 200'(1'b0));

    // Plain commit.
    r = '0; r.pc = 32'h1c000000; r.gr_we = 1'b1; r.dest = 5'd5; r.result = 32'hdeadbeef;
    step(1'b1, r, 1'b0, 32'h0, 1'b0);
    step(1'b0, z, 1'b0, 32'h0, 1'b0);
    chk("plain_rf_we", 200'(rf_we), 200'(1'b1));
    chk("plain_waddr", 200'(rf_waddr), 200'(5'd5));
    chk("plain_wdata", 200'(rf_wdata), 200'(32'hdeadbeef));
    step(1'b0, z, 1'b0, 32'h0, 1'b0);
    chk("plain_retired", 200'(inst_retired), 200'(32'd1));

    // CSR read data replaces the result.
    r.csr_re = 1'b1;
    step(1'b1, r, 1'b0, 32'h0, 1'b0);
    step(1'b0, z, 1'b0, 32'h12345678, 1'b0);
    chk("csr_rd_wdata", 200'(rf_wdata), 200'(32'h12345678));

    // Exception suppresses GPR and CSR writes; stage empties afterwards.
    r = '0; r.ex = 1'b1; r.ecode = 6'h0b; r.gr_we = 1'b1; r.csr_we = 1'b1; r.dest = 5'd7;
    step(1'b1, r, 1'b0, 32'h0, 1'b0);
    step(1'b0, z, 1'b0, 32'h0, 1'b0);
    chk("ex_wb_ex", 200'(wb_ex), 200'(1'b1));
    chk("ex_rf_we", 200'(rf_we), 200'(1'b0));
    chk("ex_bus_csr_we", 200'(wb_csr_bus[198]), 200'(1'b0));
    chk("ex_target", 200'(flush_target), 200'(32'h1c008000));
    step(1'b0, z, 1'b1, 32'h0, 1'b0);
    chk("ex_after_empty", 200'(wb_ex), 200'(1'b0));

    // Interrupt on a plain instruction.
    r = '0; r.gr_we = 1'b1; r.dest = 5'd3; r.ecode = 6'h2a;
    step(1'b1, r, 1'b0, 32'h0, 1'b0);
    ret_snap = inst_retired;
    step(1'b0, z, 1'b1, 32'h0, 1'b0);
    chk("int_wb_ex", 200'(wb_ex), 200'(1'b1));
    chk("int_ecode", 200'(wb_csr_bus[87:82]), 200'(6'h00));
    step(1'b0, z, 1'b0, 32'h0, 1'b0);
    chk("int_retired", 200'(inst_retired), 200'(ret_snap));

    // ertn alone, then ertn with an exception.
    r = '0; r.ertn = 1'b1;
    step(1'b1, r, 1'b0, 32'h0, 1'b0);
    step(1'b0, z, 1'b0, 32'h0, 1'b0);
    chk("ertn_flush", 200'(ertn_flush), 200'(1'b1));
    chk("ertn_target", 200'(flush_target), 200'(32'h1c000100));
    r.ex = 1'b1;
    step(1'b1, r, 1'b0, 32'h0, 1'b0);
    step(1'b0, z, 1'b0, 32'h0, 1'b0);
    chk("ertn_ex_flush", 200'(ertn_flush), 200'(1'b0));

    // Flush and accept in the same cycle drops the incoming instruction.
    r = '0; r.ex = 1'b1;
    step(1'b1, r, 1'b0, 32'h0, 1'b0);
    r = '0; r.gr_we = 1'b1; r.dest = 5'd9;
    step(1'b1, r, 1'b0, 32'h0, 1'b0);
    step(1'b0, z, 1'b0, 32'h0, 1'b0);
    chk("flush_drop_rf_we", 200'(rf_we), 200'(1'b0));

    // Back-to-back, then reset with an instruction resident.
    for (int i = 0; i < 4; i++) begin
      r = '0; r.gr_we = 1'b1; r.dest = 5'(i + 1); r.result = 32'(i * 17);
      step(1'b1, r, 1'b0, 32'h0, 1'b0);
    end
    step(1'b1, r, 1'b0, 32'h0, 1'b1);
    step(1'b0, z, 1'b1, 32'h0, 1'b0);
    chk("rst_mid_rf_we", 200'(rf_we), 200'(1'b0));
    chk("rst_mid_wb_ex", 200'(wb_ex), 200'(1'b0));
    chk("rst_mid_retired", 200'(inst_retired), 200'(32'd0));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), rand_rec(), ($urandom_range(0, 7) == 0),
           $urandom, ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
